// File: rtl/pipe_pkg.sv
// Shared types for the ID/EX stage: control-field widths, operand forward
// selection codes and the bubble loaded on flush or load-use stall.
package pipe_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int CTRL_W       = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rd;
    logic              regwen;
    logic              memread;
  } ex_ctl_t;

  localparam ex_ctl_t EX_BUBBLE = '{
    valid:   1'b0,
    ctrl:    {CTRL_W{1'b0}},
    rd:      5'd0,
    regwen:  1'b0,
    memread: 1'b0
  };

  // A stage is a producer for rs only if it writes a real register (x0 never counts).
  function automatic logic is_src(input logic regwen, input logic [4:0] rd, input logic [4:0] rs);
    return regwen && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_operand_if.sv
// Bundle of decode, RegFile, MEM/WB feedback and ID/EX outputs around the
// ID/EX operand stage; master drives the stage inputs, slave is the stage.
interface id_ex_operand_if
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic              id_regwen;
  logic              id_memread;
  logic [XLEN-1:0]   rf_data1;
  logic [XLEN-1:0]   rf_data2;
  logic              flush;
  logic              hold;
  logic [4:0]        mem_rd;
  logic              mem_regwen;
  logic              mem_memread;
  logic [XLEN-1:0]   mem_result;
  logic [4:0]        wb_rd;
  logic              wb_regwen;
  logic [XLEN-1:0]   wb_data;

  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic              ex_regwen;
  logic              ex_memread;
  logic [XLEN-1:0]   ex_op1;
  logic [XLEN-1:0]   ex_op2;
  fwd_sel_e          fwd_sel1;
  fwd_sel_e          fwd_sel2;
  logic              stall_o;

  modport master (
    output id_valid, id_pc, id_imm, id_ctrl, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_regwen, id_memread,
           rf_data1, rf_data2, flush, hold,
           mem_rd, mem_regwen, mem_memread, mem_result,
           wb_rd, wb_regwen, wb_data,
    input  ex_valid, ex_pc, ex_imm, ex_ctrl, ex_rs1, ex_rs2, ex_rd,
           ex_regwen, ex_memread, ex_op1, ex_op2, fwd_sel1, fwd_sel2, stall_o
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_ctrl, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_regwen, id_memread,
           rf_data1, rf_data2, flush, hold,
           mem_rd, mem_regwen, mem_memread, mem_result,
           wb_rd, wb_regwen, wb_data,
    output ex_valid, ex_pc, ex_imm, ex_ctrl, ex_rs1, ex_rs2, ex_rd,
           ex_regwen, ex_memread, ex_op1, ex_op2, fwd_sel1, fwd_sel2, stall_o
  );

endinterface

// File: rtl/id_ex_operand_fwd_unit.sv
// Per-operand forwarding mux for the EX stage: youngest ALU producer in MEM
// wins over WB, otherwise the value captured at ID/EX is used.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [4:0]      ex_rs,
  input  logic [XLEN-1:0] captured,
  input  logic [4:0]      mem_rd,
  input  logic            mem_regwen,
  input  logic            mem_memread,
  input  logic [XLEN-1:0] mem_result,
  input  logic [4:0]      wb_rd,
  input  logic            wb_regwen,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] op,
  output fwd_sel_e        sel
);

  // A load in MEM has no data yet, so it is skipped and WB is considered instead.
  always_comb begin
    op  = captured;
    sel = FWD_RF;
    if (is_src(mem_regwen && !mem_memread, mem_rd, ex_rs)) begin
      op  = mem_result;
      sel = FWD_MEM;
    end else if (is_src(wb_regwen, wb_rd, ex_rs)) begin
      op  = wb_data;
      sel = FWD_WB;
    end else begin
      op  = captured;
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/id_ex_operand.sv
// ID/EX pipeline register with WB capture bypass, load-use stall detection
// and EX-side operand forwarding from MEM and WB.
module id_ex_operand
  import pipe_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter bit WB_BYPASS = 1'b1
) (
  input logic            clk,
  input logic            rst,
  id_ex_operand_if.slave bus
);

  ex_ctl_t         ctl_d, ctl_q;
  logic [XLEN-1:0] pc_d, pc_q, imm_d, imm_q;
  logic [XLEN-1:0] op1_d, op1_q, op2_d, op2_q;
  logic [4:0]      rs1_d, rs1_q, rs2_d, rs2_q;
  logic            load_in_ex_s, rs_hit_s, stall_s;
  logic [XLEN-1:0] cap1_s, cap2_s;

  // Load-use hazard and RegFile read values patched for the missing write-through.
  always_comb begin
    load_in_ex_s = ctl_q.valid && ctl_q.memread && ctl_q.regwen && (ctl_q.rd != 5'd0);
    rs_hit_s     = (bus.id_uses_rs1 && (bus.id_rs1 == ctl_q.rd)) ||
                   (bus.id_uses_rs2 && (bus.id_rs2 == ctl_q.rd));
    stall_s      = !bus.flush && bus.id_valid && load_in_ex_s && rs_hit_s;
    if (WB_BYPASS && is_src(bus.wb_regwen, bus.wb_rd, bus.id_rs1)) begin
      cap1_s = bus.wb_data;
    end else begin
      cap1_s = bus.rf_data1;
    end
    if (WB_BYPASS && is_src(bus.wb_regwen, bus.wb_rd, bus.id_rs2)) begin
      cap2_s = bus.wb_data;
    end else begin
      cap2_s = bus.rf_data2;
    end
  end

  // Next ID/EX contents: flush > hold > load-use bubble > capture.
  always_comb begin
    ctl_d = ctl_q;
    pc_d  = pc_q;
    imm_d = imm_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    op1_d = op1_q;
    op2_d = op2_q;
    if (bus.flush || (!bus.hold && stall_s)) begin
      ctl_d = EX_BUBBLE;
      pc_d  = {XLEN{1'b0}};
      imm_d = {XLEN{1'b0}};
      rs1_d = 5'd0;
      rs2_d = 5'd0;
      op1_d = {XLEN{1'b0}};
      op2_d = {XLEN{1'b0}};
    end else if (bus.hold) begin
      ctl_d = ctl_q;
      pc_d  = pc_q;
    end else begin
      ctl_d.valid   = bus.id_valid;
      ctl_d.ctrl    = bus.id_ctrl;
      ctl_d.rd      = bus.id_rd;
      ctl_d.regwen  = bus.id_regwen;
      ctl_d.memread = bus.id_memread;
      pc_d          = bus.id_pc;
      imm_d         = bus.id_imm;
      rs1_d         = bus.id_rs1;
      rs2_d         = bus.id_rs2;
      op1_d         = cap1_s;
      op2_d         = cap2_s;
    end
  end

  // ID/EX state register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q <= EX_BUBBLE;
      pc_q  <= {XLEN{1'b0}};
      imm_q <= {XLEN{1'b0}};
      rs1_q <= 5'd0;
      rs2_q <= 5'd0;
      op1_q <= {XLEN{1'b0}};
      op2_q <= {XLEN{1'b0}};
    end else begin
      ctl_q <= ctl_d;
      pc_q  <= pc_d;
      imm_q <= imm_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
    end
  end

  fwd_unit #(.XLEN(XLEN)) u_fwd1 (
    .ex_rs      (rs1_q),
    .captured   (op1_q),
    .mem_rd     (bus.mem_rd),
    .mem_regwen (bus.mem_regwen),
    .mem_memread(bus.mem_memread),
    .mem_result (bus.mem_result),
    .wb_rd      (bus.wb_rd),
    .wb_regwen  (bus.wb_regwen),
    .wb_data    (bus.wb_data),
    .op         (bus.ex_op1),
    .sel        (bus.fwd_sel1)
  );

  fwd_unit #(.XLEN(XLEN)) u_fwd2 (
    .ex_rs      (rs2_q),
    .captured   (op2_q),
    .mem_rd     (bus.mem_rd),
    .mem_regwen (bus.mem_regwen),
    .mem_memread(bus.mem_memread),
    .mem_result (bus.mem_result),
    .wb_rd      (bus.wb_rd),
    .wb_regwen  (bus.wb_regwen),
    .wb_data    (bus.wb_data),
    .op         (bus.ex_op2),
    .sel        (bus.fwd_sel2)
  );

  assign bus.ex_valid   = ctl_q.valid;
  assign bus.ex_pc      = pc_q;
  assign bus.ex_imm     = imm_q;
  assign bus.ex_ctrl    = ctl_q.ctrl;
  assign bus.ex_rs1     = rs1_q;
  assign bus.ex_rs2     = rs2_q;
  assign bus.ex_rd      = ctl_q.rd;
  assign bus.ex_regwen  = ctl_q.regwen;
  assign bus.ex_memread = ctl_q.memread;
  assign bus.stall_o    = stall_s;

endmodule

// File: tb/tb_id_ex_operand.sv
// Bench for id_ex_operand: directed pipeline scenarios followed by random
// traffic, all compared against a behavioural model of the ID/EX stage.
module tb_id_ex_operand;
  import pipe_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_operand_if #(.XLEN(XLEN)) bus ();

  id_ex_operand #(.XLEN(XLEN), .WB_BYPASS(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit model_known = 1'b0;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [15:0] ctrl;
    logic [4:0]  rs1, rs2, rd;
    logic        regwen, memread;
    logic [31:0] op1, op2;
  } ex_m_t;

  ex_m_t m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Value an instruction sees for rs when reading in ID: a same-cycle WB write shows through.
  function automatic logic [31:0] id_read(input logic [4:0] rs, input logic [31:0] rf);
    if (rs != 5'd0 && bus.wb_regwen && bus.wb_rd == rs) return bus.wb_data;
    return rf;
  endfunction

  // Newest finished result for rs among MEM (non-load) then WB; x0 is never produced.
  function automatic void fwd_ref(input logic [4:0] rs, input logic [31:0] cap,
                                  output logic [31:0] val, output logic [1:0] sel);
    val = cap;
    sel = 2'd0;
    if (rs != 5'd0) begin
      if (bus.mem_regwen && !bus.mem_memread && bus.mem_rd == rs) begin
        val = bus.mem_result;
        sel = 2'd1;
      end else if (bus.wb_regwen && bus.wb_rd == rs) begin
        val = bus.wb_data;
        sel = 2'd2;
      end
    end
  endfunction

  function automatic logic stall_ref();
    logic load_pending;
    logic needs;
    load_pending = m.valid && m.memread && m.regwen && (m.rd != 5'd0);
    needs = (bus.id_uses_rs1 && bus.id_rs1 == m.rd) || (bus.id_uses_rs2 && bus.id_rs2 == m.rd);
    return !bus.flush && bus.id_valid && load_pending && needs;
  endfunction

  task automatic idle();
    bus.id_valid = 1'b0; bus.id_pc = 32'd0; bus.id_imm = 32'd0; bus.id_ctrl = 16'd0;
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_rd = 5'd0;
    bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0; bus.id_regwen = 1'b0; bus.id_memread = 1'b0;
    bus.rf_data1 = 32'd0; bus.rf_data2 = 32'd0; bus.flush = 1'b0; bus.hold = 1'b0;
    bus.mem_rd = 5'd0; bus.mem_regwen = 1'b0; bus.mem_memread = 1'b0; bus.mem_result = 32'd0;
    bus.wb_rd = 5'd0; bus.wb_regwen = 1'b0; bus.wb_data = 32'd0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic wen, input logic mrd);
    bus.id_valid = 1'b1; bus.id_pc = $urandom; bus.id_imm = $urandom; bus.id_ctrl = 16'($urandom);
    bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
    bus.id_uses_rs1 = u1; bus.id_uses_rs2 = u2; bus.id_regwen = wen; bus.id_memread = mrd;
    bus.rf_data1 = $urandom; bus.rf_data2 = $urandom;
  endtask

  task automatic settle();
    logic [31:0] v;
    logic [1:0]  s;
    #1;
    if (model_known) begin
      chk("stall_o", 64'(bus.stall_o), 64'(stall_ref()));
      fwd_ref(m.rs1, m.op1, v, s);
      chk("ex_op1", 64'(bus.ex_op1), 64'(v));
      chk("fwd_sel1", 64'(bus.fwd_sel1), 64'(s));
      fwd_ref(m.rs2, m.op2, v, s);
      chk("ex_op2", 64'(bus.ex_op2), 64'(v));
      chk("fwd_sel2", 64'(bus.fwd_sel2), 64'(s));
    end
  endtask

  task automatic tick();
    ex_m_t nx;
    ex_m_t zero;
    zero = '{valid: 1'b0, pc: 32'd0, imm: 32'd0, ctrl: 16'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
             regwen: 1'b0, memread: 1'b0, op1: 32'd0, op2: 32'd0};
    nx = m;
    if (rst || bus.flush) begin
      nx = zero;
    end else if (bus.hold) begin
      nx = m;
    end else if (stall_ref()) begin
      nx = zero;
    end else begin
      nx.valid = bus.id_valid; nx.pc = bus.id_pc; nx.imm = bus.id_imm; nx.ctrl = bus.id_ctrl;
      nx.rs1 = bus.id_rs1; nx.rs2 = bus.id_rs2; nx.rd = bus.id_rd;
      nx.regwen = bus.id_regwen; nx.memread = bus.id_memread;
      nx.op1 = id_read(bus.id_rs1, bus.rf_data1);
      nx.op2 = id_read(bus.id_rs2, bus.rf_data2);
    end
    @(posedge clk);
    #1;
    if (rst) model_known = 1'b1;
    m = nx;
    if (model_known) begin
      chk("ex_valid", 64'(bus.ex_valid), 64'(m.valid));
      chk("ex_pc", 64'(bus.ex_pc), 64'(m.pc));
      chk("ex_imm", 64'(bus.ex_imm), 64'(m.imm));
      chk("ex_ctrl", 64'(bus.ex_ctrl), 64'(m.ctrl));
      chk("ex_rs1", 64'(bus.ex_rs1), 64'(m.rs1));
      chk("ex_rs2", 64'(bus.ex_rs2), 64'(m.rs2));
      chk("ex_rd", 64'(bus.ex_rd), 64'(m.rd));
      chk("ex_regwen", 64'(bus.ex_regwen), 64'(m.regwen));
      chk("ex_memread", 64'(bus.ex_memread), 64'(m.memread));
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    logic [31:0] held_pc;
    logic [4:0]  held_rd;

    // Reset held two cycles with a valid instruction presented.
    @(negedge clk);
    idle();
    rst = 1'b1;
    set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    step();
    settle();
    chk("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("rst_ex_regwen", 64'(bus.ex_regwen), 64'd0);
    chk("rst_ex_op1", 64'(bus.ex_op1), 64'd0);
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    rst = 1'b0;

    // MEM beats WB for the same register.
    idle();
    set_id(5'd3, 5'd9, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    idle();
    bus.mem_rd = 5'd3; bus.mem_regwen = 1'b1; bus.mem_result = 32'hBABABABA;
    bus.wb_rd = 5'd3; bus.wb_regwen = 1'b1; bus.wb_data = 32'h11111111;
    settle();
    chk("memwb_op1", 64'(bus.ex_op1), 64'h0BABABABA);
    chk("memwb_sel1", 64'(bus.fwd_sel1), 64'd1);
    tick();

    // Load-use: one bubble, then the consumer gets the load data from WB.
    idle();
    set_id(5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    set_id(5'd4, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    held_pc = bus.id_pc;
    settle();
    chk("lu_stall", 64'(bus.stall_o), 64'd1);
    tick();
    chk("lu_bubble", 64'(bus.ex_valid), 64'd0);
    bus.mem_rd = 5'd4; bus.mem_regwen = 1'b1; bus.mem_memread = 1'b1; bus.mem_result = $urandom;
    settle();
    chk("lu_stall_drop", 64'(bus.stall_o), 64'd0);
    tick();
    idle();
    bus.wb_rd = 5'd4; bus.wb_regwen = 1'b1; bus.wb_data = 32'hDEAD0004;
    settle();
    chk("lu_ex_valid", 64'(bus.ex_valid), 64'd1);
    chk("lu_ex_pc", 64'(bus.ex_pc), 64'(held_pc));
    chk("lu_op1", 64'(bus.ex_op1), 64'h0DEAD0004);
    chk("lu_sel1", 64'(bus.fwd_sel1), 64'd2);
    tick();

    // x0 is never a forward or stall source.
    idle();
    set_id(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    bus.rf_data1 = 32'd0; bus.rf_data2 = 32'd0;
    step();
    bus.mem_rd = 5'd0; bus.mem_regwen = 1'b1; bus.mem_result = 32'hFFFFFFFF;
    bus.wb_rd = 5'd0; bus.wb_regwen = 1'b1; bus.wb_data = 32'h12345678;
    set_id(5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    chk("x0_op1", 64'(bus.ex_op1), 64'd0);
    chk("x0_sel1", 64'(bus.fwd_sel1), 64'd0);
    chk("x0_stall", 64'(bus.stall_o), 64'd0);
    tick();

    // WB bypass at capture covers the RegFile's missing write-through.
    idle();
    set_id(5'd1, 5'd5, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0);
    bus.rf_data2 = 32'd0;
    bus.wb_rd = 5'd5; bus.wb_regwen = 1'b1; bus.wb_data = 32'hCAFEF00D;
    step();
    idle();
    settle();
    chk("byp_op2", 64'(bus.ex_op2), 64'h0CAFEF00D);
    chk("byp_sel2", 64'(bus.fwd_sel2), 64'd0);
    tick();

    // Flush wins over hold and over a pending load-use.
    idle();
    set_id(5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    set_id(5'd4, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    bus.flush = 1'b1; bus.hold = 1'b1;
    settle();
    chk("fl_stall", 64'(bus.stall_o), 64'd0);
    tick();
    chk("fl_valid", 64'(bus.ex_valid), 64'd0);
    chk("fl_rd", 64'(bus.ex_rd), 64'd0);
    chk("fl_ctrl", 64'(bus.ex_ctrl), 64'd0);

    // Hold alone freezes ID/EX for three cycles.
    idle();
    set_id(5'd2, 5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    held_pc = bus.id_pc;
    held_rd = bus.id_rd;
    step();
    for (int k = 0; k < 3; k++) begin
      set_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'b1, 1'b1, 1'b1, 1'b0);
      bus.hold = 1'b1;
      step();
    end
    chk("hold_pc", 64'(bus.ex_pc), 64'(held_pc));
    chk("hold_rd", 64'(bus.ex_rd), 64'(held_rd));
    chk("hold_valid", 64'(bus.ex_valid), 64'd1);

    // Reset during a stall drops stall_o after the reset edge.
    idle();
    set_id(5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    set_id(5'd4, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    settle();
    chk("rs_stall_before", 64'(bus.stall_o), 64'd1);
    tick();
    settle();
    chk("rs_stall_after", 64'(bus.stall_o), 64'd0);
    tick();
    rst = 1'b0;

    // Random traffic on a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      set_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0));
      bus.id_valid    = ($urandom_range(0, 4) != 0);
      rst             = ($urandom_range(0, 49) == 0);
      bus.flush       = ($urandom_range(0, 9) == 0);
      bus.hold        = ($urandom_range(0, 6) == 0);
      bus.mem_rd      = 5'($urandom_range(0, 7));
      bus.mem_regwen  = 1'($urandom);
      bus.mem_memread = 1'($urandom);
      bus.mem_result  = $urandom;
      bus.wb_rd       = 5'($urandom_range(0, 7));
      bus.wb_regwen   = 1'($urandom);
      bus.wb_data     = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_operand.md
ID_EX_OPERAND -- requirements
Module: id_ex_operand

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter WB_BYPASS, default 1, enables WB-to-ID capture bypass because RegFile is built without write-through.
REQ-003 SHALL have ports clk in 1, the single clock; rst in 1, reset (synchronous, active-high).
REQ-004 SHALL have ID inputs id_valid 1, id_pc XLEN, id_imm XLEN, id_ctrl CTRL_W, id_rs1/id_rs2/id_rd 5, id_uses_rs1/id_uses_rs2 1, id_regwen 1, id_memread 1.
REQ-005 SHALL have RegFile inputs rf_data1/rf_data2 XLEN, the read data for id_rs1/id_rs2 this cycle.
REQ-006 SHALL have control inputs flush 1 (branch taken, squash ID/EX) and hold 1 (downstream stall, freeze ID/EX).
REQ-007 SHALL have MEM inputs mem_rd 5, mem_regwen 1, mem_memread 1, mem_result XLEN.
REQ-008 SHALL have WB inputs wb_rd 5, wb_regwen 1, wb_data XLEN, the same values driving RegFile rsW/RegWEn/dataW.
REQ-009 SHALL have registered outputs ex_valid, ex_pc, ex_imm, ex_ctrl, ex_rs1, ex_rs2, ex_rd, ex_regwen, ex_memread.
REQ-010 SHALL have combinational outputs ex_op1/ex_op2 XLEN (forwarded operands), fwd_sel1/fwd_sel2 2 (fwd_sel_e), stall_o 1 (hold PC and IF/ID).

Function
REQ-011 Register update priority SHALL be rst > flush > hold > load-use bubble > capture, evaluated at each rising clk edge.
REQ-012 flush=1 SHALL load a bubble: ex_valid, ex_regwen, ex_memread=0, ex_ctrl=0, ex_rd=0; other fields don't-care but SHALL be zeroed.
REQ-013 hold=1 (no flush) SHALL keep every ID/EX register unchanged.
REQ-014 stall_o SHALL equal !flush & id_valid & ex_valid & ex_memread & ex_regwen & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)), combinational, same cycle.
REQ-015 stall_o=1 with hold=0, flush=0 SHALL load a bubble; the held ID instruction is captured the following cycle, giving exactly one bubble per load-use.
REQ-016 Capture SHALL copy all id_* fields to ex_*, with ex_valid=id_valid; latency ID->EX is one cycle.
REQ-017 Captured operand n SHALL be wb_data when WB_BYPASS=1, wb_regwen=1, wb_rd!=0, wb_rd==id_rsn; else rf_datan.
REQ-018 ex_opn SHALL select, in priority: MEM (mem_regwen & !mem_memread & mem_rd!=0 & mem_rd==ex_rsn) -> mem_result; WB (wb_regwen & wb_rd!=0 & wb_rd==ex_rsn) -> wb_data; else captured value.
REQ-019 fwd_seln SHALL report the REQ-018 selection: FWD_RF=0, FWD_MEM=1, FWD_WB=2; value 3 never driven.
REQ-020 Register x0 SHALL never be a forward, bypass or stall source, regardless of regwen.
REQ-021 Forwarding SHALL stay active while hold=1 (frozen EX re-evaluated each cycle).

Reset
REQ-022 rst=1 at a clk edge SHALL clear every ID/EX register to 0, including ex_valid, ex_regwen, ex_memread.
REQ-023 While rst=1, stall_o SHALL be 0 once the reset edge has been seen (ex_valid=0), and fwd_sel1/2 SHALL be FWD_RF unless MEM/WB inputs match ex_rs=0 (never, per REQ-020).
REQ-024 Reset asserted mid-stall SHALL drop stall_o the cycle after the reset edge; no bubble accounting persists.

Structure
REQ-025 Package pipe_pkg SHALL hold XLEN default, CTRL_W=16, fwd_sel_e enum, and the bubble constant.
REQ-026 Forward selection SHALL be a combinational sub-module fwd_unit, instantiated once per operand.
REQ-027 Block SHALL contain no latches; expected size 150-250 RTL lines.

Verification
REQ-028 Reset: rst=1 for 2 cycles with id_valid=1 -> ex_valid=0, ex_regwen=0, ex_op1=0, stall_o=0.
REQ-029 MEM vs WB: ex_rs1=3, mem_rd=3 mem_regwen=1 mem_result=0xBABABABA, wb_rd=3 wb_data=0x11111111 -> ex_op1=0xBABABABA, fwd_sel1=1.
REQ-030 Load-use: ex holds lw rd=4, id add rs1=4 -> stall_o=1 same cycle; next cycle ex_valid=0; cycle after, add captured, ex_op1=wb_data via fwd_sel1=2.
REQ-031 x0: mem_rd=0 mem_regwen=1 mem_result=0xFFFFFFFF, ex_rs1=0 -> ex_op1=0, fwd_sel1=0; ex lw rd=0 -> stall_o=0.
REQ-032 WB bypass: wb_rd=5 wb_regwen=1 wb_data=0xCAFEF00D, id_rs2=5, rf_data2=0 -> after edge ex_op2=0xCAFEF00D with no MEM/WB match, fwd_sel2=0.
REQ-033 Simultaneous: flush=1, hold=1, load-use condition true -> stall_o=0, bubble loaded; hold alone for 3 cycles -> ex_* unchanged.
